// File: rtl/hex_display_scanner.sv
// rtl/hex_display_scanner.sv - multiplexed hex digit scanner with one-entry pending value (HEX_SCAN_LEADING_ZERO_BLANK_EN enables leading-zero blanking)
module hex_display_scanner #(
  parameter int NUM_DIGITS = 6,
  parameter int SCAN_DIV   = 50000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [4*NUM_DIGITS-1:0] in_value,
  output logic [3:0]              digit_num,
  output logic [NUM_DIGITS-1:0]   digit_sel,
  output logic                    digit_blank,
  output logic                    frame_done
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PS_W  = $clog2(SCAN_DIV);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(SCAN_DIV - 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [PS_W-1:0]         prescaler_q, prescaler_d;
  logic [IDX_W-1:0]        index_q, index_d;
  logic [4*NUM_DIGITS-1:0] display_q, display_d;
  logic [4*NUM_DIGITS-1:0] pending_q, pending_d;
  logic                    pending_valid_q, pending_valid_d;
  logic [NUM_DIGITS-1:0]   digit_sel_q, digit_sel_d;
  logic [3:0]              digit_num_q, digit_num_d;
  logic                    digit_blank_q, digit_blank_d;
  logic                    frame_done_q, frame_done_d;

  logic transfer;
  logic tick;
  logic boundary;

  // Before the first value the block always accepts; afterwards only when pending is free.
  assign in_ready = (state_q == ST_IDLE) || !pending_valid_q;
  assign transfer = in_valid && in_ready;
  assign tick     = (state_q == ST_SCAN) && (prescaler_q == PS_LAST);
  assign boundary = tick && (index_q == IDX_LAST);

  assign digit_sel   = digit_sel_q;
  assign digit_num   = digit_num_q;
  assign digit_blank = digit_blank_q;
  assign frame_done  = frame_done_q;

  // State register and all datapath registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      prescaler_q     <= '0;
      index_q         <= '0;
      display_q       <= '0;
      pending_q       <= '0;
      pending_valid_q <= 1'b0;
      digit_sel_q     <= '0;
      digit_num_q     <= '0;
      digit_blank_q   <= 1'b1;
      frame_done_q    <= 1'b0;
    end else begin
      state_q         <= state_d;
      prescaler_q     <= prescaler_d;
      index_q         <= index_d;
      display_q       <= display_d;
      pending_q       <= pending_d;
      pending_valid_q <= pending_valid_d;
      digit_sel_q     <= digit_sel_d;
      digit_num_q     <= digit_num_d;
      digit_blank_q   <= digit_blank_d;
      frame_done_q    <= frame_done_d;
    end
  end

  // Next state: first value goes straight to the display, later ones wait in pending for a frame boundary.
  always_comb begin
    state_d         = state_q;
    prescaler_d     = prescaler_q;
    index_d         = index_q;
    display_d       = display_q;
    pending_d       = pending_q;
    pending_valid_d = pending_valid_q;
    frame_done_d    = boundary;
    unique case (state_q)
      ST_IDLE: begin
        if (transfer) begin
          state_d     = ST_SCAN;
          display_d   = in_value;
          prescaler_d = '0;
          index_d     = '0;
        end
      end
      ST_SCAN: begin
        if (tick) begin
          prescaler_d = '0;
          index_d     = boundary ? '0 : index_q + 1'b1;
        end else begin
          prescaler_d = prescaler_q + 1'b1;
        end
        // Pending is only swapped in at the boundary so a frame never mixes two values.
        if (boundary && pending_valid_q) begin
          display_d       = pending_q;
          pending_valid_d = 1'b0;
        end
        // A transfer needs pending empty, so it never collides with the swap above.
        if (transfer) begin
          pending_d       = in_value;
          pending_valid_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef HEX_SCAN_LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] lead_zero;

  // Flag every digit above 0 whose own nibble and all higher nibbles are zero.
  always_comb begin
    logic run;
    lead_zero = '0;
    run       = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      run          = run && (display_d[4*k +: 4] == 4'h0);
      lead_zero[k] = run;
    end
  end
`endif

  // Output decode from next-state values so the registered outputs move with the index.
  always_comb begin
    digit_sel_d   = '0;
    digit_num_d   = 4'h0;
    digit_blank_d = 1'b1;
    if (state_d == ST_SCAN) begin
      digit_blank_d = 1'b0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
        if (index_d == IDX_W'(k)) begin
          digit_sel_d[k] = 1'b1;
          digit_num_d    = display_d[4*k +: 4];
`ifdef HEX_SCAN_LEADING_ZERO_BLANK_EN
          if (lead_zero[k]) begin
            digit_sel_d[k] = 1'b0;
            digit_blank_d  = 1'b1;
          end
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_hex_display_scanner.sv
// tb/tb_hex_display_scanner.sv - randomized bench for hex_display_scanner against a frame-level reference model
module tb_hex_display_scanner;

  localparam int N = 6;
  localparam int D = 4;
  localparam int FRAME = N * D;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [23:0]   in_value = '0;
  logic [3:0]    digit_num;
  logic [N-1:0]  digit_sel;
  logic          digit_blank;
  logic          frame_done;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: time is counted in SCAN cycles, digit and frame derive from it arithmetically.
  bit          m_scan;
  int          m_c;
  logic [23:0] m_disp;
  logic [23:0] m_pend;
  bit          m_pend_v;
  bit          m_fd;

  hex_display_scanner #(.NUM_DIGITS(N), .SCAN_DIV(D)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_value   (in_value),
    .digit_num  (digit_num),
    .digit_sel  (digit_sel),
    .digit_blank(digit_blank),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_scan = 0; m_c = 0; m_disp = '0; m_pend = '0; m_pend_v = 0; m_fd = 0;
  endtask

  function automatic bit exp_ready();
    return !m_scan || !m_pend_v;
  endfunction

  task automatic model_step(input bit tr, input logic [23:0] val);
    bit bnd;
    if (!m_scan) begin
      m_fd = 0;
      if (tr) begin
        m_scan = 1; m_disp = val; m_c = 0;
      end
    end else begin
      bnd  = (m_c % FRAME) == FRAME - 1;
      m_fd = bnd;
      if (bnd && m_pend_v) begin
        m_disp = m_pend; m_pend_v = 0;
      end
      if (tr) begin
        m_pend = val; m_pend_v = 1;
      end
      m_c++;
    end
  endtask

  task automatic check_outputs(input string ph);
    int          idx;
    logic [23:0] hi;
    logic [N-1:0] e_sel;
    logic [3:0]  e_num;
    logic        e_blank;
    e_sel = '0; e_num = '0; e_blank = 1'b1;
    if (m_scan) begin
      idx     = (m_c / D) % N;
      hi      = m_disp >> (4 * idx);
      e_sel   = N'(1) << idx;
      e_num   = hi[3:0];
      e_blank = 1'b0;
`ifdef HEX_SCAN_LEADING_ZERO_BLANK_EN
      if (idx > 0 && hi == 24'h0) begin
        e_sel   = '0;
        e_blank = 1'b1;
      end
`endif
    end
    check({ph, ".sel"},   32'(digit_sel),   32'(e_sel));
    check({ph, ".num"},   32'(digit_num),   32'(e_num));
    check({ph, ".blank"}, 32'(digit_blank), 32'(e_blank));
    check({ph, ".fd"},    32'(frame_done),  32'(m_fd));
  endtask

  // One clock: drive at the negedge, predict, then compare on the next negedge.
  task automatic cycle(input string ph, input logic v, input logic [23:0] val);
    bit tr;
    in_valid = v;
    in_value = val;
    #1;
    check({ph, ".ready"}, 32'(in_ready), 32'(exp_ready()));
    tr = v && exp_ready();
    model_step(tr, val);
    @(posedge clk);
    @(negedge clk);
    check_outputs(ph);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_value = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_outputs("rst");
    check("rst.ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);
    check_outputs("post_rst");
  endtask

  function automatic logic [23:0] rand_value();
    logic [31:0] mask;
    int k;
    case ($urandom_range(0, 3))
      0: return 24'h0;
      1: begin
        k    = $urandom_range(1, 5);
        mask = (32'h1 << (4 * k)) - 32'h1;
        return 24'($urandom & mask);
      end
      default: return 24'($urandom);
    endcase
  endfunction

  initial begin
    bit found;
    @(negedge clk);
    do_reset();

    // Fixed value, two full frames of scan.
    cycle("seq", 1'b1, 24'h12AB3F);
    check("seq.first_num", 32'(digit_num), 32'hF);
    check("seq.first_sel", 32'(digit_sel), 32'h01);
    repeat (2 * FRAME) cycle("seq", 1'b0, '0);

    // Zero value offered mid-frame at digit 2.
    while (((m_c / D) % N) != 2) cycle("mid", 1'b0, '0);
    cycle("mid", 1'b1, 24'h000000);
    check("mid.pend_ready", 32'(in_ready), 32'd0);
    repeat (FRAME) cycle("mid", 1'b1, 24'h654321);
    repeat (2 * FRAME) cycle("mid", 1'b0, '0);

    // Transfer exactly on the boundary cycle with pending empty.
    found = 0;
    for (int i = 0; i < 4 * FRAME && !found; i++) begin
      if (m_scan && !m_pend_v && (m_c % FRAME) == FRAME - 1) found = 1;
      else cycle("bnd", 1'b0, '0);
    end
    check("bnd.reached", 32'(found), 32'd1);
    cycle("bnd", 1'b1, 24'hFEDCBA);
    repeat (2 * FRAME + 2) cycle("bnd", 1'b0, '0);

    // Small value exercises leading zeros.
    do_reset();
    cycle("lz", 1'b1, 24'h00000A);
    repeat (FRAME + 2) cycle("lz", 1'b0, '0);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++)
      cycle("rnd", ($urandom_range(0, 5) == 0), rand_value());

    // Asynchronous reset at digit 3, away from any clock edge.
    while (((m_c / D) % N) != 3) cycle("arst", 1'b0, '0);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_outputs("arst");
    check("arst.ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_outputs("arst_rel");
    cycle("arst_rel", 1'b1, 24'h987654);
    repeat (FRAME + 2) cycle("arst_rel", 1'b0, '0);

    for (int i = 0; i < 500; i++)
      cycle("rnd2", ($urandom_range(0, 3) == 0), rand_value());

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
